cpu_datapath: RTL
=================

Name: cpu_datapath

Overview:
- Register-transfer datapath driven by the microprogrammed control unit.
- Consumes the CU's 32-bit one-hot-OR `control_signal` bus once per clock.
- Holds PC, MAR, MBR, IR, BR, ACC and MR, and drives the memory port.
- Returns the latched opcode (`data_from_ir`) and status `flags` to the CU, closing the CU↔datapath loop.

Parameters:
- DATA_W, 16, word width of MBR/BR/ACC/MR/memory data; instruction = {opcode[15:8], address[7:0]}
- ADDR_W, 8, width of PC/MAR/memory address

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- control_signal  input  32  micro-operation bits from CU (bit map below)
- mem_rdata  input  DATA_W  asynchronous-read memory data for address mem_addr
- mem_addr  output  ADDR_W  = MAR (combinational)
- mem_wdata  output  DATA_W  = MBR (combinational)
- mem_we  output  1  = control_signal[12] (combinational)
- data_from_ir  output  8  registered opcode for CU dispatch
- flags  output  8  status to CU
- dp_busy  output  1  divider in progress (0 without the optional feature)

Behaviour:
- Bit map, fixed:
  - 0 mar2memory (no effect, address is always MAR)
  - 1 pc2mbr, 2 pc2mar, 3 mbr2pc, 4 mbr2ir, 5 memory2mbr, 6 mbr2br
  - 7 acc2alu, 14 br2alu: ignored, operands hardwired ACC, BR
  - 8 mbr2mar, 9 div_operation (optional feature), 10 mbr2acc, 11 acc2mbr, 12 mbr2memory
  - 13 ir2cu, 15 mr2mbr, 16 alu2mbr
  - 17–19 CAR controls: ignored
  - 20 pc_plus1, 21 acc_clear, 22 add, 23 sub, 24 and, 25 or, 26 not, 27 lsl, 28 lsr, 29 mpy, 30 asl, 31 asr
- Reset (rst=1 at edge): PC, MAR, MBR, IR, BR, ACC, MR, data_from_ir, carry, overflow, dp_busy all 0. Reset mid-operation (including an active divide) aborts immediately.
- Register-transfer semantics: every transfer in a cycle reads pre-edge values. Example: mbr2mar|pc_plus1 gives MAR ← old MBR[7:0] and PC ← PC+1 on the same edge.
- Destinations:
  - MAR ← MBR[7:0] (mbr2mar) over PC (pc2mar).
  - PC ← MBR[7:0] (mbr2pc) over PC+1 (pc_plus1). PC wraps 0xFF→0x00.
  - MBR source priority: memory2mbr > alu2mbr (ACC) > mr2mbr > acc2mbr > pc2mbr (zero-extended).
  - IR ← MBR[15:8] on mbr2ir.
  - data_from_ir ← IR on ir2cu. One-cycle latency: IR written on cycle n is visible via ir2cu at n+1.
  - BR ← MBR on mbr2br.
  - ACC priority: acc_clear > ALU op > mbr2acc (ACC ← MBR).
  - Multiple ALU bits set: lowest-numbered bit wins.
- ALU ops (result to ACC, one cycle):
  - add: ACC+BR, carry = carry-out, overflow = signed overflow.
  - sub: ACC−BR, carry = no-borrow, overflow = signed overflow.
  - and, or: bitwise with BR.
  - not: ~BR.
  - lsl/lsr: shift by 1, zero fill, carry = bit shifted out.
  - asl: shift left by 1, overflow = sign changed.
  - asr: shift right by 1, sign fill.
  - mpy: signed ACC×BR, {MR,ACC} ← 2·DATA_W product.
  - Carry and overflow update only on ALU ops that define them; otherwise they hold.
- mem_we: asserted for exactly the cycles with bit 12 set; memory writes MBR at MAR on that edge.
- flags:
  - [0] = ACC[DATA_W-1] (negative; CU takes jmpgez when 0)
  - [1] = (ACC==0)
  - [2] = carry, [3] = overflow
  - [4] = div-by-zero (optional feature)
  - [7:5] = 0
  - [1:0] are combinational from the ACC register.

Optional Feature:
- Macro CPU_DATAPATH_DIV_EN.
- Defined: bit 9 with dp_busy=0 starts an unsigned restoring divide.
  - dp_busy=1 for exactly DATA_W cycles, during which all control_signal bits are ignored.
  - At completion: ACC ← ACC/BR, MR ← ACC%BR, dp_busy=0.
  - BR=0: finishes in 1 cycle, ACC ← all ones, MR ← ACC, flags[4] ← 1. flags[4] is cleared by the next successful divide or by reset.
- Undefined: bit 9 ignored, dp_busy and flags[4] tied 0.

Test Plan:
- Reset, then mem[0]=0x0205. Cycle 1 memory2mbr → MBR=0x0205. Cycle 2 mbr2ir → IR=0x02. Cycle 3 ir2cu → data_from_ir=0x02.
- MBR=0x0010, PC=0x07: assert mbr2mar|pc_plus1 → MAR=0x10, PC=0x08 same edge. Assert mbr2mar|pc2mar → MAR=0x10.
- ACC=0x7FFF, BR=0x0001, add → ACC=0x8000, flags=0x09. Then acc_clear|add → ACC=0, flags[1]=1.
- ACC=0xFFFE (−2), BR=0x0003, mpy → MR=0xFFFF, ACC=0xFFFA. Then alu2mbr|mr2mbr → MBR=0xFFFA.
- MBR=0x1234, MAR=0x20: mbr2memory → mem_we=1 for one cycle only, mem[0x20]=0x1234. PC=0xFF, pc_plus1 → PC=0x00.
- DIV_EN: ACC=100, BR=7, bit 9 → dp_busy high 16 cycles, add ignored mid-way, then ACC=14, MR=2. BR=0 → ACC=0xFFFF, flags[4]=1. rst mid-divide → all 0.

Source files
------------

// File: rtl/cpu_datapath.sv
// Register-transfer datapath (PC, MAR, MBR, IR, BR, ACC, MR) driven by the CU's 32-bit control word.
// Optional unsigned restoring divider on control bit 9, enabled by defining CPU_DATAPATH_DIV_EN.
module cpu_datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       control_signal,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [7:0]        data_from_ir,
  output logic [7:0]        flags,
  output logic              dp_busy
);

  localparam int MSB = DATA_W - 1;

  localparam int B_PC2MBR    = 1;
  localparam int B_PC2MAR    = 2;
  localparam int B_MBR2PC    = 3;
  localparam int B_MBR2IR    = 4;
  localparam int B_MEM2MBR   = 5;
  localparam int B_MBR2BR    = 6;
  localparam int B_MBR2MAR   = 8;
  localparam int B_DIV       = 9;
  localparam int B_MBR2ACC   = 10;
  localparam int B_ACC2MBR   = 11;
  localparam int B_MBR2MEM   = 12;
  localparam int B_IR2CU     = 13;
  localparam int B_MR2MBR    = 15;
  localparam int B_ALU2MBR   = 16;
  localparam int B_PC_PLUS1  = 20;
  localparam int B_ACC_CLEAR = 21;
  localparam int B_ADD       = 22;
  localparam int B_SUB       = 23;
  localparam int B_AND       = 24;
  localparam int B_OR        = 25;
  localparam int B_NOT       = 26;
  localparam int B_LSL       = 27;
  localparam int B_LSR       = 28;
  localparam int B_MPY       = 29;
  localparam int B_ASL       = 30;
  localparam int B_ASR       = 31;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic [7:0]        ir;
  logic [DATA_W-1:0] br;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mr;
  logic              carry;
  logic              ovf;

  // While the divider runs the whole control word is masked off.
  logic [31:0] ctl;
  assign ctl = dp_busy ? 32'd0 : control_signal;

  // Bits with no datapath effect (address select, operand selects, CAR controls).
  logic unused_ctrl;
  assign unused_ctrl = ^{ctl[0], ctl[7], ctl[B_DIV], ctl[14], ctl[19:17]};

  assign mem_addr  = mar;
  assign mem_wdata = mbr;
  assign mem_we    = ctl[B_MBR2MEM];

  // ---------------- ALU ----------------
  logic [DATA_W:0]     sum_ext;
  logic [DATA_W:0]     diff_ext;
  logic [2*DATA_W-1:0] acc_sx;
  logic [2*DATA_W-1:0] br_sx;
  logic [2*DATA_W-1:0] prod;

  assign sum_ext  = {1'b0, acc} + {1'b0, br};
  assign diff_ext = {1'b0, acc} - {1'b0, br};
  assign acc_sx   = {{DATA_W{acc[MSB]}}, acc};
  assign br_sx    = {{DATA_W{br[MSB]}}, br};
  // Low 2*DATA_W bits of the sign-extended product equal the signed product.
  assign prod     = acc_sx * br_sx;

  logic              alu_hit;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] alu_mr;
  logic              alu_carry;
  logic              alu_ovf;

  always_comb begin
    alu_hit   = 1'b1;
    alu_res   = acc;
    alu_mr    = mr;
    alu_carry = carry;
    alu_ovf   = ovf;
    if (ctl[B_ADD]) begin
      alu_res   = sum_ext[MSB:0];
      alu_carry = sum_ext[DATA_W];
      alu_ovf   = (acc[MSB] == br[MSB]) && (sum_ext[MSB] != acc[MSB]);
    end else if (ctl[B_SUB]) begin
      alu_res   = diff_ext[MSB:0];
      alu_carry = ~diff_ext[DATA_W];
      alu_ovf   = (acc[MSB] != br[MSB]) && (diff_ext[MSB] != acc[MSB]);
    end else if (ctl[B_AND]) begin
      alu_res = acc & br;
    end else if (ctl[B_OR]) begin
      alu_res = acc | br;
    end else if (ctl[B_NOT]) begin
      alu_res = ~br;
    end else if (ctl[B_LSL]) begin
      alu_res   = {acc[MSB-1:0], 1'b0};
      alu_carry = acc[MSB];
    end else if (ctl[B_LSR]) begin
      alu_res   = {1'b0, acc[MSB:1]};
      alu_carry = acc[0];
    end else if (ctl[B_MPY]) begin
      alu_res = prod[MSB:0];
      alu_mr  = prod[2*DATA_W-1:DATA_W];
    end else if (ctl[B_ASL]) begin
      alu_res = {acc[MSB-1:0], 1'b0};
      alu_ovf = acc[MSB] ^ acc[MSB-1];
    end else if (ctl[B_ASR]) begin
      alu_res = {acc[MSB], acc[MSB:1]};
    end else begin
      alu_hit = 1'b0;
    end
  end

  // ---------------- divider ----------------
  logic              div_wr;
  logic [DATA_W-1:0] div_acc_val;
  logic [DATA_W-1:0] div_mr_val;
  logic              div_flag;

`ifdef CPU_DATAPATH_DIV_EN
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic              div_busy;
  logic              div_zero;
  logic [CNT_W-1:0]  div_cnt;
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_rem;
  logic [DATA_W-1:0] div_dvs;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_try;
  logic [DATA_W-1:0] rem_next;
  logic              q_bit;
  logic              div_start;
  logic              div_by_zero;
  logic              div_done;

  assign div_start   = ctl[B_DIV];
  assign div_by_zero = div_start && (br == '0);
  assign rem_shift   = {div_rem, div_quo[MSB]};
  assign rem_try     = rem_shift - {1'b0, div_dvs};
  // A borrow out of the trial subtraction means the quotient bit is 0 and the remainder is restored.
  assign q_bit       = ~rem_try[DATA_W];
  assign rem_next    = q_bit ? rem_try[MSB:0] : rem_shift[MSB:0];
  assign div_done    = div_busy && (div_cnt == CNT_LAST);
  assign div_wr      = div_done || div_by_zero;
  assign div_acc_val = div_busy ? {div_quo[MSB-1:0], q_bit} : {DATA_W{1'b1}};
  assign div_mr_val  = div_busy ? rem_next : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_busy <= 1'b0;
      div_zero <= 1'b0;
      div_cnt  <= '0;
      div_quo  <= '0;
      div_rem  <= '0;
      div_dvs  <= '0;
    end else if (div_busy) begin
      div_quo <= {div_quo[MSB-1:0], q_bit};
      div_rem <= rem_next;
      div_cnt <= div_cnt + CNT_W'(1);
      if (div_done) begin
        div_busy <= 1'b0;
        div_zero <= 1'b0;
      end
    end else if (div_by_zero) begin
      div_zero <= 1'b1;
    end else if (div_start) begin
      div_busy <= 1'b1;
      div_cnt  <= '0;
      div_quo  <= acc;
      div_rem  <= '0;
      div_dvs  <= br;
    end
  end

  assign dp_busy  = div_busy;
  assign div_flag = div_zero;
`else
  assign dp_busy     = 1'b0;
  assign div_wr      = 1'b0;
  assign div_acc_val = '0;
  assign div_mr_val  = '0;
  assign div_flag    = 1'b0;
`endif

  assign flags = {3'b000, div_flag, ovf, carry, (acc == '0), acc[MSB]};

  // ---------------- register transfers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      mar          <= '0;
      mbr          <= '0;
      ir           <= '0;
      br           <= '0;
      acc          <= '0;
      mr           <= '0;
      data_from_ir <= '0;
      carry        <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      if (ctl[B_MBR2MAR])      mar <= mbr[ADDR_W-1:0];
      else if (ctl[B_PC2MAR])  mar <= pc;

      if (ctl[B_MBR2PC])        pc <= mbr[ADDR_W-1:0];
      else if (ctl[B_PC_PLUS1]) pc <= pc + ADDR_W'(1);

      if (ctl[B_MEM2MBR])      mbr <= mem_rdata;
      else if (ctl[B_ALU2MBR]) mbr <= acc;
      else if (ctl[B_MR2MBR])  mbr <= mr;
      else if (ctl[B_ACC2MBR]) mbr <= acc;
      else if (ctl[B_PC2MBR])  mbr <= {{(DATA_W-ADDR_W){1'b0}}, pc};

      if (ctl[B_MBR2IR]) ir <= mbr[MSB -: 8];
      if (ctl[B_IR2CU])  data_from_ir <= ir;
      if (ctl[B_MBR2BR]) br <= mbr;

      if (div_wr) begin
        acc <= div_acc_val;
        mr  <= div_mr_val;
      end else if (ctl[B_ACC_CLEAR]) begin
        acc <= '0;
      end else if (alu_hit) begin
        acc   <= alu_res;
        mr    <= alu_mr;
        carry <= alu_carry;
        ovf   <= alu_ovf;
      end else if (ctl[B_MBR2ACC]) begin
        acc <= mbr;
      end
    end
  end

endmodule
